gp10_periph: RTL and testbench

// - GP10 memory-mapped I/O peripheral: the downstream consumer of the gp10_* strobes from mem_control (word 1024).
// - Holds one 16-bit output register that drives LEDR and four active-low 7-segment displays.
// - Returns a synchronised, debounced switch word with a sticky "changed" flag on reads.

---
 rtl/gp10_pkg.sv | 39 +++
 rtl/gp10_debounce.sv | 50 +++++
 rtl/gp10_periph.sv | 79 +++++++
 tb/tb_gp10_periph.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/gp10_pkg.sv
// Shared definitions for the GP10 memory-mapped I/O peripheral.
// Holds the bus word address, the HEX display constants and the 7-segment decoder.
package gp10_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned SEG_W  = 7;
    localparam int unsigned NIB_W  = 4;
    localparam int unsigned N_HEX  = 4;

    localparam logic [10:0]      GP10_WORD_ADDR = 11'd1024;
    localparam logic [SEG_W-1:0] SEG7_BLANK     = 7'h7F;
    localparam logic [SEG_W-1:0] SEG7_ZERO      = 7'b1000000;

    // Active-low hex digit decoder, bit order {g,f,e,d,c,b,a}.
    function automatic logic [SEG_W-1:0] seg7(input logic [NIB_W-1:0] nib);
        logic [SEG_W-1:0] seg;
        case (nib)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            4'hF:    seg = 7'b0001110;
            default: seg = SEG7_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/gp10_debounce.sv
// Two-flop synchroniser followed by a whole-vector debounce counter.
// accept_c is high for the single cycle on whose edge sw_stable takes the synced value.
module gp10_debounce
    import gp10_pkg::*;
#(
    parameter int unsigned N          = 10,
    parameter int unsigned DEB_CYCLES = 50000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] sw,
    output logic [N-1:0] sw_stable,
    output logic         accept_c
);

    localparam int unsigned     CNT_W    = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [N-1:0]     sw_meta;
    logic [N-1:0]     sw_sync;
    logic [CNT_W-1:0] deb_cnt;

    assign accept_c = (sw_sync != sw_stable) && (deb_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= sw;
            sw_sync <= sw_meta;
        end
    end

    // A return to the stable value restarts the window; other changes keep counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_stable <= '0;
            deb_cnt   <= '0;
        end else if (sw_sync == sw_stable) begin
            deb_cnt <= '0;
        end else if (accept_c) begin
            sw_stable <= sw_sync;
            deb_cnt   <= '0;
        end else begin
            deb_cnt <= deb_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/gp10_periph.sv
// GP10 I/O peripheral: output register driving LEDR and four HEX displays,
// plus a debounced switch word with a sticky change flag on the read port.
module gp10_periph
    import gp10_pkg::*;
#(
    parameter int unsigned N_SW       = 10,
    parameter int unsigned DEB_CYCLES = 50000
) (
    input  logic              CLK,
    input  logic              RST_n,
    input  logic              gp10_memw,
    input  logic              gp10_read_en,
    input  logic [DATA_W-1:0] gp10_dataw,
    output logic [DATA_W-1:0] gp10_datar,
    input  logic [N_SW-1:0]   SW,
    output logic [N_SW-1:0]   LEDR,
    output logic [SEG_W-1:0]  HEX0,
    output logic [SEG_W-1:0]  HEX1,
    output logic [SEG_W-1:0]  HEX2,
    output logic [SEG_W-1:0]  HEX3
);

    logic [N_SW-1:0]             out_reg;
    logic [N_HEX-1:0][SEG_W-1:0] hex_q;
    logic [N_SW-1:0]             sw_stable;
    logic                        accept_c;
    logic                        chg;

    gp10_debounce #(
        .N          (N_SW),
        .DEB_CYCLES (DEB_CYCLES)
    ) u_debounce (
        .clk       (CLK),
        .rst_n     (RST_n),
        .sw        (SW),
        .sw_stable (sw_stable),
        .accept_c  (accept_c)
    );

    // Segment patterns are decoded at write time so the displays come straight from flops.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            out_reg <= '0;
            for (int i = 0; i < int'(N_HEX); i++) begin
                hex_q[i] <= SEG7_ZERO;
            end
        end else if (gp10_memw) begin
            out_reg <= gp10_dataw[N_SW-1:0];
            for (int i = 0; i < int'(N_HEX); i++) begin
                hex_q[i] <= seg7(gp10_dataw[NIB_W*i +: NIB_W]);
            end
        end
    end

    // Acceptance takes priority over a concurrent read clear.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            chg <= 1'b0;
        end else if (accept_c) begin
            chg <= 1'b1;
        end else if (gp10_read_en) begin
            chg <= 1'b0;
        end
    end

    assign LEDR = out_reg;
    assign HEX0 = hex_q[0];
    assign HEX1 = hex_q[1];
    assign HEX2 = hex_q[2];
    assign HEX3 = hex_q[3];

    // Read word is driven from registers only, so it is valid in the read-strobe cycle.
    always_comb begin
        gp10_datar             = '0;
        gp10_datar[N_SW-1:0]   = sw_stable;
        gp10_datar[DATA_W-1]   = chg;
    end

endmodule

// File: tb/tb_gp10_periph.sv
// Directed bench for gp10_periph with a cycle-level behavioural model and literal pins.
module tb_gp10_periph;

    localparam int N   = 10;
    localparam int DEB = 4;

    localparam logic [6:0] SEG_TBL [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic        CLK = 1'b0;
    logic        RST_n = 1'b0;
    logic        gp10_memw = 1'b0;
    logic        gp10_read_en = 1'b0;
    logic [15:0] gp10_dataw = '0;
    logic [15:0] gp10_datar;
    logic [N-1:0] SW = '0;
    logic [N-1:0] LEDR;
    logic [6:0]  HEX0, HEX1, HEX2, HEX3;

    int n_checks = 0;
    int n_fail   = 0;

    gp10_periph #(.N_SW(N), .DEB_CYCLES(DEB)) dut (
        .CLK          (CLK),
        .RST_n        (RST_n),
        .gp10_memw    (gp10_memw),
        .gp10_read_en (gp10_read_en),
        .gp10_dataw   (gp10_dataw),
        .gp10_datar   (gp10_datar),
        .SW           (SW),
        .LEDR         (LEDR),
        .HEX0         (HEX0),
        .HEX1         (HEX1),
        .HEX2         (HEX2),
        .HEX3         (HEX3)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: last written word, SW seen two edges late, and a run-length of
    // consecutive cycles where the synced word differs from the accepted word.
    logic [15:0]  m_out = '0;
    logic [N-1:0] m_hist0 = '0;
    logic [N-1:0] m_hist1 = '0;
    logic [N-1:0] m_stable = '0;
    int           m_run = 0;
    logic         m_chg = 1'b0;
    logic         m_acc;

    always @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            m_out = '0; m_hist0 = '0; m_hist1 = '0;
            m_stable = '0; m_run = 0; m_chg = 1'b0;
        end else begin
            m_acc = 1'b0;
            if (gp10_memw) m_out = gp10_dataw;
            if (m_hist1 != m_stable) begin
                m_run = m_run + 1;
                if (m_run == DEB) begin
                    m_stable = m_hist1;
                    m_run = 0;
                    m_acc = 1'b1;
                end
            end else begin
                m_run = 0;
            end
            if (m_acc) m_chg = 1'b1;
            else if (gp10_read_en) m_chg = 1'b0;
            m_hist1 = m_hist0;
            m_hist0 = SW;
        end
    end

    function automatic logic [15:0] m_datar();
        logic [15:0] d;
        d = 16'(m_stable);
        d[15] = m_chg;
        return d;
    endfunction

    always @(negedge CLK) begin
        chk("cmp_ledr",  32'(LEDR),       32'(m_out[N-1:0]));
        chk("cmp_hex0",  32'(HEX0),       32'(SEG_TBL[m_out[3:0]]));
        chk("cmp_hex1",  32'(HEX1),       32'(SEG_TBL[m_out[7:4]]));
        chk("cmp_hex2",  32'(HEX2),       32'(SEG_TBL[m_out[11:8]]));
        chk("cmp_hex3",  32'(HEX3),       32'(SEG_TBL[m_out[15:12]]));
        chk("cmp_datar", 32'(gp10_datar), 32'(m_datar()));
    end

    task automatic step();
        @(negedge CLK);
        #1;
    endtask

    initial begin
        // T1: power-on reset, a write, then asynchronous reset mid-cycle
        step(); step();
        RST_n = 1'b1;
        step();
        gp10_memw = 1'b1; gp10_dataw = 16'hABCD;
        step();
        gp10_memw = 1'b0;
        chk("t1_ledr_written", 32'(LEDR), 32'h3CD);
        @(posedge CLK); #2;
        RST_n = 1'b0;
        #1;
        chk("t1_ledr_rst", 32'(LEDR), 32'h0);
        chk("t1_hex0_rst", 32'(HEX0), 32'b1000000);
        chk("t1_hex3_rst", 32'(HEX3), 32'b1000000);
        chk("t1_datar_rst", 32'(gp10_datar), 32'h0);
        step();
        RST_n = 1'b1;
        step();

        // T2: single write
        gp10_memw = 1'b1; gp10_dataw = 16'h1234;
        step();
        gp10_memw = 1'b0;
        chk("t2_ledr", 32'(LEDR), 32'h234);
        chk("t2_hex0", 32'(HEX0), 32'b0011001);
        chk("t2_hex1", 32'(HEX1), 32'b0110000);
        chk("t2_hex2", 32'(HEX2), 32'b0100100);
        chk("t2_hex3", 32'(HEX3), 32'b1111001);

        // Back-to-back writes: last one wins
        gp10_memw = 1'b1; gp10_dataw = 16'h0F0F;
        step();
        gp10_dataw = 16'hFEDC;
        step();
        gp10_memw = 1'b0;
        chk("b2b_ledr", 32'(LEDR), 32'h2DC);
        chk("b2b_hex0", 32'(HEX0), 32'b1000110);
        chk("b2b_hex1", 32'(HEX1), 32'b0100001);
        chk("b2b_hex2", 32'(HEX2), 32'b0000110);
        chk("b2b_hex3", 32'(HEX3), 32'b0001110);

        // T3: debounce acceptance after 2 + DEB edges, then read clears chg
        SW = 10'h155;
        for (int i = 1; i <= 5; i++) begin
            step();
            chk("t3_pending", 32'(gp10_datar), 32'h0);
        end
        step();
        chk("t3_accept", 32'(gp10_datar), 32'h8155);
        gp10_read_en = 1'b1;
        #1;
        chk("t3_read", 32'(gp10_datar), 32'h8155);
        step();
        gp10_read_en = 1'b0;
        chk("t3_after_read", 32'(gp10_datar), 32'h0155);

        // T4: bounce rejected (start from a clean reset with SW low)
        SW = '0;
        RST_n = 1'b0;
        step();
        RST_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            SW = (i % 2 == 0) ? 10'h001 : 10'h000;
            step(); step();
        end
        step(); step(); step(); step();
        chk("t4_no_accept", 32'(gp10_datar), 32'h0);

        // T5: read strobe on the acceptance edge; set wins
        SW = 10'h2AA;
        for (int i = 1; i <= 5; i++) step();
        gp10_read_en = 1'b1;
        #1;
        chk("t5_pre_edge", 32'(gp10_datar), 32'h0);
        step();
        gp10_read_en = 1'b0;
        chk("t5_set_wins", 32'(gp10_datar), 32'h82AA);

        // T6: reset at count 2 discards the pending value
        SW = '0;
        RST_n = 1'b0;
        step();
        RST_n = 1'b1;
        step();
        SW = 10'h3FF;
        for (int i = 1; i <= 4; i++) step();
        RST_n = 1'b0;
        #2;
        RST_n = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            chk("t6_pending", 32'(gp10_datar), 32'h0);
        end
        step();
        chk("t6_accept", 32'(gp10_datar), 32'h83FF);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
